gate_response_checker: RTL and testbench
========================================

# gate_response_checker

Hardware self-checking sequencer for small combinational lab gates. It is the response side of the exhaustive-stimulus benches used for the gate labs. On a Start pulse it applies every input combination to the device under test and waits a fixed settle time. It samples the DUT output and compares it against a parameterised truth table, then reports pass/fail, an error count and a per-vector failure map. It sits on the board between the push-button/switch logic and the gate under test, with results driving LEDs.

## Interface
- N_IN, default 2: number of DUT inputs (1..4).
- TRUTH, default 4'b1000: expected output table, width 2**N_IN. Bit i is the expected F for input vector i. The default is a 2-input AND.
- SETTLE, default 2: cycles the vector is held before the check cycle (1..255).

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  level; sampled only in IDLE or DONE.
- F_i  in  1  DUT output.
- Vec_o  out  N_IN  DUT inputs. Bit 0 = X, bit 1 = Y, and so on.
- Busy  out  1  high while a run is in progress.
- Done  out  1  high from run completion until the next Start or Rst.
- Pass  out  1  valid when Done=1; 1 iff no mismatches.
- ErrCount  out  N_IN+1  number of mismatching vectors.
- FailVec  out  2**N_IN  bit i set iff vector i mismatched.

## Operation
- Reset: on an edge with Rst=1, go to IDLE and set every output to 0 (Vec_o, Busy, Done, Pass, ErrCount, FailVec). Rst overrides all other inputs, including mid-run.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, Start=1: go to SETTLE. Busy<=1, Vec_o<=0, ErrCount<=0, FailVec<=0, Done<=0, Pass<=0, settle counter<=0.
- SETTLE: the counter increments each edge. On the edge where the counter reaches SETTLE-1, go to CHECK. Vec_o is held.
- CHECK (one cycle): compare F_i against TRUTH[Vec_o].
  - On mismatch: ErrCount<=ErrCount+1 and FailVec[Vec_o]<=1.
  - If Vec_o is not all-ones: Vec_o<=Vec_o+1, counter<=0, go to SETTLE.
  - If Vec_o is all-ones: go to DONE. Busy<=0, Done<=1, and Pass<=1 iff the final ErrCount is 0. The final ErrCount includes this cycle's comparison.
- DONE: all results held. Vec_o holds all-ones; it does not wrap. Start=1 restarts exactly as from IDLE, clearing the previous results on that edge.
- Start is ignored in SETTLE and CHECK.
- ErrCount cannot overflow: the maximum is 2**N_IN, which fits in N_IN+1 bits.
- F_i is used only in CHECK. Glitches during SETTLE have no effect.

## Timing
- Let edge 0 be the edge that samples Start=1.
  - Vector k is driven from edge k*(SETTLE+1).
  - Vector k is compared at edge (k+1)*(SETTLE+1).
- Each vector is held SETTLE+1 cycles, and F_i is sampled on the last of them.
- Done, Pass and the final ErrCount/FailVec are visible after edge 2**N_IN*(SETTLE+1). Busy falls on that same edge.
- With the defaults, the run is 12 cycles: Done rises after edge 12.
- ErrCount and FailVec update on each CHECK edge, so partial results are visible during a run.
- A restart from DONE shows Busy=1 and Done=0 one edge after Start is sampled. There are no idle cycles in between.

## Test plan
- **Correct AND DUT** (defaults, F_i = X&Y), one-cycle Start pulse:
  - Vec_o = 0,1,2,3, each held 3 cycles.
  - After edge 12: Done=1, Pass=1, ErrCount=0, FailVec=4'b0000, Busy=0.
- **OR gate wired as DUT** (F_i = X|Y): after edge 12, ErrCount=2, FailVec=4'b0110, Pass=0.
- **F_i stuck at 0**: ErrCount=1, FailVec=4'b1000, Pass=0. ErrCount is still 0 after edge 9 and becomes 1 after edge 12.
- **Rst=1 on edge 5 mid-run**: after that edge all outputs are 0 and the FSM is in IDLE. A following Start runs the full 12-cycle sequence with correct results.
- **Start held high continuously**: it has no effect during the run. In DONE, the next edge restarts: results are cleared, Busy=1, Vec_o=0. Runs repeat back-to-back with a 13-cycle period.
- **N_IN=3, TRUTH=8'h80, SETTLE=1, correct 3-input AND**: Vec_o steps 0..7, two cycles each. Done after edge 16, Pass=1, ErrCount=4'd0.

Source files
------------

// File: rtl/gate_response_checker.sv
// gate_response_checker: exhaustive response checker for small combinational
// lab gates. Steps Vec_o through every input combination, holds each one for
// SETTLE cycles plus one check cycle, compares F_i against the TRUTH table and
// accumulates an error count and a per-vector failure map.
module gate_response_checker #(
  parameter int                 N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 4'b1000,
  parameter int                 SETTLE = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic                F_i,
  output logic [N_IN-1:0]     Vec_o,
  output logic                Busy,
  output logic                Done,
  output logic                Pass,
  output logic [N_IN:0]       ErrCount,
  output logic [2**N_IN-1:0]  FailVec
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // The settle counter counts 0..SETTLE-1; SETTLE is at most 255.
  localparam logic [7:0]      CNT_LAST = 8'(SETTLE - 1);
  localparam logic [7:0]      CNT_ONE  = 8'd1;
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

  state_t               state;
  state_t               state_nxt;
  logic [7:0]           cnt;
  logic [7:0]           cnt_nxt;
  logic [N_IN-1:0]      vec_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 pass_nxt;
  logic [N_IN:0]        err_nxt;
  logic [2**N_IN-1:0]   fail_nxt;
  logic                 mismatch;
  logic                 last_vec;

  // Expected gate output for a given input vector.
  function automatic logic expected_f(input logic [N_IN-1:0] v);
    return TRUTH[v];
  endfunction

  assign last_vec = &Vec_o;
  // F_i only matters in the check cycle; anything it does during settle is ignored.
  assign mismatch = (state == S_CHECK) && (F_i != expected_f(Vec_o));

  // State and result registers; reset clears everything.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      Vec_o    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
      ErrCount <= '0;
      FailVec  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      Vec_o    <= vec_nxt;
      Busy     <= busy_nxt;
      Done     <= done_nxt;
      Pass     <= pass_nxt;
      ErrCount <= err_nxt;
      FailVec  <= fail_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (Start) state_nxt = S_SETTLE;
      S_SETTLE:       if (cnt == CNT_LAST) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = last_vec ? S_DONE : S_SETTLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Next values of the counter, stimulus vector and result outputs.
  always_comb begin
    cnt_nxt  = cnt;
    vec_nxt  = Vec_o;
    busy_nxt = Busy;
    done_nxt = Done;
    pass_nxt = Pass;
    err_nxt  = ErrCount;
    fail_nxt = FailVec;
    case (state)
      S_IDLE, S_DONE: begin
        // A restart from DONE clears the previous results on the same edge.
        if (Start) begin
          cnt_nxt  = '0;
          vec_nxt  = '0;
          busy_nxt = 1'b1;
          done_nxt = 1'b0;
          pass_nxt = 1'b0;
          err_nxt  = '0;
          fail_nxt = '0;
        end
      end
      S_SETTLE: begin
        cnt_nxt = cnt + CNT_ONE;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_nxt         = ErrCount + ERR_ONE;
          fail_nxt[Vec_o] = 1'b1;
        end
        if (last_vec) begin
          // Vec_o stays at all-ones; Pass reflects the count including this check.
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
          pass_nxt = (err_nxt == '0);
        end else begin
          vec_nxt = Vec_o + VEC_ONE;
          cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed testbench for gate_response_checker: a default 2-input instance
// driven by a behavioural gate model, and a 3-input AND instance with SETTLE=1.
module tb_gate_response_checker;

  logic       clk;
  logic       rst;

  // Default instance: N_IN=2, TRUTH=AND, SETTLE=2
  logic       start;
  logic       f;
  logic [1:0] vec;
  logic       busy, done, pass;
  logic [2:0] err;
  logic [3:0] fvec;
  int         mode;   // 0: AND, 1: OR, 2: stuck at 0

  // Second instance: N_IN=3, TRUTH=8'h80, SETTLE=1
  logic       start3;
  logic       f3;
  logic [2:0] vec3;
  logic       busy3, done3, pass3;
  logic [3:0] err3;
  logic [7:0] fvec3;

  int n_tests = 0;
  int n_fail  = 0;

  gate_response_checker #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(2)) dut (
    .Clk(clk), .Rst(rst), .Start(start), .F_i(f),
    .Vec_o(vec), .Busy(busy), .Done(done), .Pass(pass),
    .ErrCount(err), .FailVec(fvec)
  );

  gate_response_checker #(.N_IN(3), .TRUTH(8'h80), .SETTLE(1)) dut3 (
    .Clk(clk), .Rst(rst), .Start(start3), .F_i(f3),
    .Vec_o(vec3), .Busy(busy3), .Done(done3), .Pass(pass3),
    .ErrCount(err3), .FailVec(fvec3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test models
  always_comb begin
    f = 1'b0;
    case (mode)
      0: f = vec[0] & vec[1];
      1: f = vec[0] | vec[1];
      default: f = 1'b0;
    endcase
  end
  assign f3 = &vec3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start sampled on the next edge (edge 0); returns 1 time unit after it.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({vec, busy, done, pass, err, fvec} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_dut2 got vec=%0d busy=%b done=%b pass=%b err=%0d fv=%b want all 0",
               vec, busy, done, pass, err, fvec);
    end
    n_tests++;
    if ({vec3, busy3, done3, pass3, err3, fvec3} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_dut3 got vec=%0d busy=%b done=%b pass=%b err=%0d fv=%b want all 0",
               vec3, busy3, done3, pass3, err3, fvec3);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_and_pass();
    mode = 0;
    pulse_start();
    for (int e = 0; e < 12; e++) begin
      if (e > 0) tick();
      n_tests++;
      if (vec !== 2'(e / 3) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL and_step e=%0d got vec=%0d busy=%b done=%b want vec=%0d busy=1 done=0",
                 e, vec, busy, done, e / 3);
      end
    end
    tick(); // edge 12
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b1 || err !== 3'd0 || fvec !== 4'b0000 ||
        busy !== 1'b0 || vec !== 2'd3) begin
      n_fail++;
      $display("FAIL and_final got done=%b pass=%b err=%0d fv=%b busy=%b vec=%0d want 1 1 0 0000 0 3",
               done, pass, err, fvec, busy, vec);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || vec !== 2'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL and_hold got done=%b vec=%0d busy=%b want 1 3 0", done, vec, busy);
    end
  endtask

  task automatic test_or_gate();
    mode = 1;
    pulse_start();  // restart from DONE
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 5) begin
        n_tests++;
        if (err !== 3'd0) begin
          n_fail++;
          $display("FAIL or_partial5 got err=%0d want 0", err);
        end
      end
      if (e == 6) begin
        n_tests++;
        if (err !== 3'd1 || fvec !== 4'b0010) begin
          n_fail++;
          $display("FAIL or_partial6 got err=%0d fv=%b want 1 0010", err, fvec);
        end
      end
      if (e == 11) begin
        n_tests++;
        if (done !== 1'b0 || err !== 3'd2) begin
          n_fail++;
          $display("FAIL or_partial11 got done=%b err=%0d want 0 2", done, err);
        end
      end
    end
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b0 || err !== 3'd2 || fvec !== 4'b0110) begin
      n_fail++;
      $display("FAIL or_final got done=%b pass=%b err=%0d fv=%b want 1 0 2 0110",
               done, pass, err, fvec);
    end
  endtask

  task automatic test_stuck0();
    mode = 2;
    pulse_start();
    n_tests++;
    if (err !== 3'd0 || fvec !== 4'b0000 || done !== 1'b0 || busy !== 1'b1 || vec !== 2'd0) begin
      n_fail++;
      $display("FAIL stuck_clear got err=%0d fv=%b done=%b busy=%b vec=%0d want 0 0000 0 1 0",
               err, fvec, done, busy, vec);
    end
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 9) begin
        n_tests++;
        if (err !== 3'd0) begin
          n_fail++;
          $display("FAIL stuck_partial9 got err=%0d want 0", err);
        end
      end
    end
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b0 || err !== 3'd1 || fvec !== 4'b1000) begin
      n_fail++;
      $display("FAIL stuck_final got done=%b pass=%b err=%0d fv=%b want 1 0 1 1000",
               done, pass, err, fvec);
    end
  endtask

  task automatic test_rst_midrun();
    mode = 0;
    pulse_start();
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    tick(); // edge 5
    rst = 1'b0;
    n_tests++;
    if ({vec, busy, done, pass, err, fvec} !== 13'd0) begin
      n_fail++;
      $display("FAIL rst_mid got vec=%0d busy=%b done=%b pass=%b err=%0d fv=%b want all 0",
               vec, busy, done, pass, err, fvec);
    end
    tick();
    tick();
    n_tests++;
    if (busy !== 1'b0 || vec !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_idle got busy=%b vec=%0d want 0 0", busy, vec);
    end
    pulse_start();
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 11) begin
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1 || vec !== 2'd3) begin
          n_fail++;
          $display("FAIL rst_rerun11 got done=%b busy=%b vec=%0d want 0 1 3", done, busy, vec);
        end
      end
    end
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b1 || err !== 3'd0 || fvec !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rerun_final got done=%b pass=%b err=%0d fv=%b busy=%b want 1 1 0 0000 0",
               done, pass, err, fvec, busy);
    end
  endtask

  task automatic test_back_to_back();
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    tick(); // edge 0
    for (int e = 1; e <= 26; e++) begin
      tick();
      if (e == 4) begin
        n_tests++;
        if (vec !== 2'd1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ignore got vec=%0d busy=%b want 1 1", vec, busy);
        end
      end
      if (e == 12 || e == 25) begin
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 3'd2 || fvec !== 4'b0110) begin
          n_fail++;
          $display("FAIL b2b_done e=%0d got done=%b busy=%b err=%0d fv=%b want 1 0 2 0110",
                   e, done, busy, err, fvec);
        end
      end
      if (e == 13 || e == 26) begin
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1 || vec !== 2'd0 || err !== 3'd0 ||
            fvec !== 4'b0000 || pass !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_restart e=%0d got done=%b busy=%b vec=%0d err=%0d fv=%b pass=%b want 0 1 0 0 0000 0",
                   e, done, busy, vec, err, fvec, pass);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_n3_and();
    @(negedge clk);
    start3 = 1'b1;
    tick(); // edge 0
    start3 = 1'b0;
    for (int e = 0; e < 16; e++) begin
      if (e > 0) tick();
      n_tests++;
      if (vec3 !== 3'(e / 2) || busy3 !== 1'b1 || done3 !== 1'b0) begin
        n_fail++;
        $display("FAIL n3_step e=%0d got vec=%0d busy=%b done=%b want vec=%0d busy=1 done=0",
                 e, vec3, busy3, done3, e / 2);
      end
    end
    tick(); // edge 16
    n_tests++;
    if (done3 !== 1'b1 || pass3 !== 1'b1 || err3 !== 4'd0 || fvec3 !== 8'h00 ||
        busy3 !== 1'b0 || vec3 !== 3'd7) begin
      n_fail++;
      $display("FAIL n3_final got done=%b pass=%b err=%0d fv=%b busy=%b vec=%0d want 1 1 0 00000000 0 7",
               done3, pass3, err3, fvec3, busy3, vec3);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    mode   = 0;
    test_reset();
    test_and_pass();
    test_or_gate();
    test_stuck0();
    test_rst_midrun();
    test_back_to_back();
    test_n3_and();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
